// File: rtl/brom_pkg.sv
// Shared FSM type and buffer sizing for the block-ROM burst reader.
package brom_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DRAIN
  } state_t;

  localparam int unsigned ROM_LAT_MAX = 3;

  function automatic int unsigned fifo_depth(input int unsigned lat);
    return lat + 2;
  endfunction

endpackage

// File: rtl/brom_burst_fifo.sv
// Small synchronous FIFO with occupancy count; the head entry is always a register.
module brom_burst_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 3
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           push,
  input  logic [WIDTH-1:0]               wdata,
  input  logic                           pop,
  output logic [WIDTH-1:0]               head,
  output logic [$clog2(DEPTH+1)-1:0]     count
);

  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic             do_push;
  logic             do_pop;
  logic [CW-1:0]    wpos;

  always_comb begin
    do_pop  = pop && (count != '0);
    do_push = push && ((count != CW'(DEPTH)) || do_pop);
    wpos    = do_pop ? count - CW'(1) : count;
  end

  // Shift-down organisation keeps the oldest word in mem[0].
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
      count <= '0;
    end else begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        if (do_push && (i == 32'(wpos))) begin
          mem[i] <= wdata;
        end else if (do_pop && (i < DEPTH - 1)) begin
          mem[i] <= mem[(i + 1) % DEPTH];
        end
      end
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  assign head = mem[0];

endmodule

// File: rtl/brom_burst_reader.sv
// Sequential/circular burst reader from a synchronous-read ROM onto a
// valid/ready stream, with credit-based flow control so no ROM data is lost.
module brom_burst_reader
  import brom_pkg::*;
#(
  parameter int unsigned ADDR_W  = 13,
  parameter int unsigned DATA_W  = 14,
  parameter int unsigned ROM_LAT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W-1:0] length,
  input  logic              circ,
  input  logic              stop,
  output logic              busy,
  output logic              done,
  output logic              rom_en,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_data,
  output logic [ADDR_W-1:0] m_index,
  output logic              m_last
);

  localparam int unsigned DEPTH = fifo_depth(ROM_LAT);
  localparam int unsigned CW    = $clog2(DEPTH + 1);
  localparam int unsigned EW    = DATA_W + ADDR_W + 1;

  state_t            state;
  logic [ADDR_W-1:0] base_q;
  logic [ADDR_W-1:0] len_q;
  logic              circ_q;
  logic [ADDR_W-1:0] offset;
  logic [ADDR_W-1:0] iss_idx;
  logic              iss_last;

  logic              pipe_v   [ROM_LAT];
  logic [ADDR_W:0]   pipe_tag [ROM_LAT];

  logic [CW-1:0]     fifo_count;
  logic [EW-1:0]     head;
  logic              push;
  logic              xfer;
  logic              credit_ok;
  logic              is_last;
  logic              issue;
  logic              drained;
  int unsigned       pending;

  // The pending transfer is credited back in the same cycle so a steady
  // stream with m_ready high sustains one read per cycle.
  always_comb begin
    pending = rom_en ? 32'd1 : 32'd0;
    for (int unsigned i = 0; i < ROM_LAT; i++) begin
      if (pipe_v[i]) pending = pending + 32'd1;
    end
    xfer      = m_valid && m_ready;
    credit_ok = (32'(fifo_count) + pending - (xfer ? 32'd1 : 32'd0)) < DEPTH;
    is_last   = (offset == len_q - ADDR_W'(1));
    issue     = (state == ISSUE) && credit_ok && (!stop || (is_last && !circ_q));
    drained   = (pending == 32'd0) &&
                ((32'(fifo_count) - (xfer ? 32'd1 : 32'd0)) == 32'd0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      base_q   <= '0;
      len_q    <= '0;
      circ_q   <= 1'b0;
      offset   <= '0;
      iss_idx  <= '0;
      iss_last <= 1'b0;
      rom_en   <= 1'b0;
      rom_addr <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      rom_en <= 1'b0;
      done   <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            base_q <= base_addr;
            len_q  <= length;
            circ_q <= circ;
            if (length == '0) begin
              done <= 1'b1;
            end else begin
              busy     <= 1'b1;
              rom_en   <= 1'b1;
              rom_addr <= base_addr;
              iss_idx  <= '0;
              iss_last <= (length == ADDR_W'(1));
              if (length == ADDR_W'(1)) begin
                offset <= '0;
                state  <= circ ? ISSUE : DRAIN;
              end else begin
                offset <= ADDR_W'(1);
                state  <= ISSUE;
              end
            end
          end
        end
        ISSUE: begin
          if (issue) begin
            rom_en   <= 1'b1;
            rom_addr <= base_q + offset;
            iss_idx  <= offset;
            iss_last <= is_last;
            offset   <= is_last ? '0 : offset + ADDR_W'(1);
          end
          if (stop || (issue && is_last && !circ_q)) begin
            state <= DRAIN;
          end
        end
        DRAIN: begin
          if (drained) begin
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Index/last tags travel alongside the read through the ROM latency.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < ROM_LAT; i++) begin
        pipe_v[i]   <= 1'b0;
        pipe_tag[i] <= '0;
      end
    end else begin
      pipe_v[0]   <= rom_en;
      pipe_tag[0] <= {iss_idx, iss_last};
      for (int unsigned i = 1; i < ROM_LAT; i++) begin
        pipe_v[i]   <= pipe_v[i-1];
        pipe_tag[i] <= pipe_tag[i-1];
      end
    end
  end

  assign push = pipe_v[ROM_LAT-1];

  brom_burst_fifo #(
    .WIDTH (EW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .wdata ({rom_data, pipe_tag[ROM_LAT-1]}),
    .pop   (xfer),
    .head  (head),
    .count (fifo_count)
  );

  assign m_valid                   = (fifo_count != '0);
  assign {m_data, m_index, m_last} = head;

endmodule

// File: tb/tb_brom_burst_reader.sv
// Bench for brom_burst_reader: one instance with ROM_LAT=1 and one with ROM_LAT=3.
module tb_brom_burst_reader;

  localparam int unsigned AW = 13;
  localparam int unsigned DW = 14;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic          start [2];
  logic [AW-1:0] base_addr [2];
  logic [AW-1:0] length [2];
  logic          circ [2];
  logic          stop [2];
  logic          busy [2];
  logic          done [2];
  logic          rom_en [2];
  logic [AW-1:0] rom_addr [2];
  logic          m_valid [2];
  logic          m_ready [2];
  logic [DW-1:0] m_data [2];
  logic [AW-1:0] m_index [2];
  logic          m_last [2];

  int unsigned checks = 0;
  int unsigned errors = 0;

  // Reference model: the word delivered k-th in a burst is offset k mod len.
  logic [AW-1:0] mbase [2];
  logic [AW-1:0] mlen [2];
  int unsigned   iss [2];
  int unsigned   xfer [2];
  logic          stopped [2];

  for (genvar g = 0; g < 2; g++) begin : g_dut
    localparam int unsigned LAT = (g == 0) ? 1 : 3;
    logic [AW-1:0] sh [LAT];
    logic [DW-1:0] rdata;

    always @(posedge clk) begin
      if (rom_en[g]) sh[0] <= rom_addr[g];
      for (int i = 1; i < LAT; i++) sh[i] <= sh[i-1];
    end
    assign rdata = {1'b0, sh[LAT-1]};

    brom_burst_reader #(
      .ADDR_W  (AW),
      .DATA_W  (DW),
      .ROM_LAT (LAT)
    ) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start[g]),
      .base_addr (base_addr[g]),
      .length    (length[g]),
      .circ      (circ[g]),
      .stop      (stop[g]),
      .busy      (busy[g]),
      .done      (done[g]),
      .rom_en    (rom_en[g]),
      .rom_addr  (rom_addr[g]),
      .rom_data  (rdata),
      .m_valid   (m_valid[g]),
      .m_ready   (m_ready[g]),
      .m_data    (m_data[g]),
      .m_index   (m_index[g]),
      .m_last    (m_last[g])
    );
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      for (int d = 0; d < 2; d++) begin
        if (stopped[d]) chk("issue_after_stop", 32'(rom_en[d]), 32'd0);
        if (rom_en[d]) begin
          if (mlen[d] != '0)
            chk("rom_addr", 32'(rom_addr[d]),
                32'(AW'(32'(mbase[d]) + iss[d] % 32'(mlen[d]))));
          iss[d]++;
        end
        chk("outstanding_le_depth", 32'((iss[d] - xfer[d]) <= ((d == 0) ? 3 : 5)), 32'd1);
        if (m_valid[d] && m_ready[d]) begin
          if (mlen[d] == '0) begin
            chk("xfer_without_burst", 32'(m_valid[d]), 32'd0);
          end else begin
            int unsigned idx;
            logic [AW-1:0] ea;
            idx = xfer[d] % 32'(mlen[d]);
            ea  = AW'(32'(mbase[d]) + idx);
            chk("m_index", 32'(m_index[d]), idx);
            chk("m_data", 32'(m_data[d]), 32'({1'b0, ea}));
            chk("m_last", 32'(m_last[d]), 32'(idx == 32'(mlen[d]) - 1));
          end
          xfer[d]++;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_burst(input int d, input logic [AW-1:0] b, input logic [AW-1:0] l,
                             input logic c);
    start[d] = 1'b1; base_addr[d] = b; length[d] = l; circ[d] = c;
    mbase[d] = b; mlen[d] = l; iss[d] = 0; xfer[d] = 0; stopped[d] = 1'b0;
    tick();
    start[d] = 1'b0;
    base_addr[d] = AW'($urandom);
    length[d] = AW'($urandom);
    circ[d] = 1'($urandom);
  endtask

  task automatic wait_done(input int d, input int unsigned max, input bit rnd,
                           output int unsigned cyc);
    cyc = 0;
    do begin
      if (rnd) m_ready[d] = 1'($urandom);
      tick();
      cyc++;
    end while (!done[d] && cyc < max);
    chk("done_seen", 32'(done[d]), 32'd1);
    chk("busy_at_done", 32'(busy[d]), 32'd0);
  endtask

  task automatic chk_reset(input int d);
    chk("rst_busy", 32'(busy[d]), 32'd0);
    chk("rst_done", 32'(done[d]), 32'd0);
    chk("rst_rom_en", 32'(rom_en[d]), 32'd0);
    chk("rst_rom_addr", 32'(rom_addr[d]), 32'd0);
    chk("rst_m_valid", 32'(m_valid[d]), 32'd0);
    chk("rst_m_data", 32'(m_data[d]), 32'd0);
    chk("rst_m_index", 32'(m_index[d]), 32'd0);
    chk("rst_m_last", 32'(m_last[d]), 32'd0);
  endtask

  task automatic run_basic();
    start_burst(0, 13'h010, 13'd4, 1'b0);
    chk("s1_rom_en", 32'(rom_en[0]), 32'd1);
    chk("s1_rom_addr", 32'(rom_addr[0]), 32'h010);
    chk("s1_busy", 32'(busy[0]), 32'd1);
    tick();
    chk("s1_valid_early", 32'(m_valid[0]), 32'd0);
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("s1_valid", 32'(m_valid[0]), 32'd1);
      chk("s1_data", 32'(m_data[0]), 32'h010 + 32'(k));
      chk("s1_last", 32'(m_last[0]), 32'(k == 3));
      chk("s1_done_low", 32'(done[0]), 32'd0);
    end
    tick();
    chk("s1_done", 32'(done[0]), 32'd1);
    chk("s1_busy_low", 32'(busy[0]), 32'd0);
    chk("s1_valid_end", 32'(m_valid[0]), 32'd0);
    tick();
    chk("s1_done_pulse", 32'(done[0]), 32'd0);
    chk("s1_count", xfer[0], 32'd4);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    int unsigned   cyc;
    bit            sent;
    logic [AW-1:0] wrap_exp [4];
    logic [AW-1:0] b;

    wrap_exp = '{13'h1FFE, 13'h1FFF, 13'h0000, 13'h0001};
    for (int d = 0; d < 2; d++) begin
      start[d] = 1'b0; base_addr[d] = '0; length[d] = '0; circ[d] = 1'b0;
      stop[d] = 1'b0; m_ready[d] = 1'b1;
      mbase[d] = '0; mlen[d] = '0; iss[d] = 0; xfer[d] = 0; stopped[d] = 1'b0;
    end
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_reset(0);
    rst_n = 1'b1;
    tick();

    run_basic();

    // Top-of-ROM wrap, then a stop while draining must be ignored.
    start_burst(0, 13'h1FFE, 13'd4, 1'b0);
    for (int k = 0; k < 4; k++) begin
      chk("wrap_addr", 32'(rom_addr[0]), 32'(wrap_exp[k]));
      tick();
    end
    stop[0] = 1'b1;
    tick();
    stop[0] = 1'b0;
    wait_done(0, 50, 1'b0, cyc);
    chk("wrap_count", xfer[0], 32'd4);

    // Full-throughput timing at ROM_LAT=3.
    start_burst(1, AW'($urandom), 13'd10, 1'b0);
    wait_done(1, 100, 1'b0, cyc);
    chk("lat3_done_cycles", cyc, 32'd14);
    chk("lat3_count", xfer[1], 32'd10);

    // Random back-pressure at ROM_LAT=3.
    start_burst(1, AW'($urandom), 13'd16, 1'b0);
    wait_done(1, 400, 1'b1, cyc);
    m_ready[1] = 1'b1;
    chk("bp_count", xfer[1], 32'd16);
    chk("bp_issued", iss[1], 32'd16);

    // Circular pass, stopped after seven transfers.
    start_burst(0, AW'($urandom), 13'd3, 1'b1);
    sent = 1'b0;
    cyc = 0;
    while (!done[0] && cyc < 200) begin
      if (!sent && xfer[0] >= 7) begin
        stop[0] = 1'b1;
        tick();
        stop[0] = 1'b0;
        stopped[0] = 1'b1;
        sent = 1'b1;
      end else begin
        tick();
      end
      cyc++;
    end
    chk("circ_done", 32'(done[0]), 32'd1);
    chk("circ_xfer_ge7", 32'(xfer[0] >= 7), 32'd1);
    chk("circ_all_delivered", xfer[0], iss[0]);
    tick();

    // Empty burst.
    start_burst(0, 13'h123, 13'd0, 1'b0);
    chk("len0_done", 32'(done[0]), 32'd1);
    chk("len0_rom_en", 32'(rom_en[0]), 32'd0);
    chk("len0_busy", 32'(busy[0]), 32'd0);
    tick();
    chk("len0_done_pulse", 32'(done[0]), 32'd0);
    chk("len0_no_issue", iss[0], 32'd0);

    // Start while busy is ignored.
    b = AW'($urandom);
    start_burst(1, b, 13'd8, 1'b0);
    tick();
    tick();
    start[1] = 1'b1; base_addr[1] = b + 13'd100; length[1] = 13'd2;
    tick();
    start[1] = 1'b0;
    wait_done(1, 100, 1'b0, cyc);
    chk("restart_done_cycles", cyc, 32'd9);
    chk("restart_count", xfer[1], 32'd8);
    tick();
    chk("restart_idle", 32'(busy[1]), 32'd0);

    // Reset mid-burst with words held in the FIFO.
    m_ready[0] = 1'b0;
    start_burst(0, 13'h040, 13'd8, 1'b0);
    tick();
    tick();
    tick();
    chk("rst_pre_valid", 32'(m_valid[0]), 32'd1);
    rst_n = 1'b0;
    #1;
    chk_reset(0);
    @(negedge clk);
    rst_n = 1'b1;
    m_ready[0] = 1'b1;
    tick();
    run_basic();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/brom_burst_reader.md
# brom_burst_reader

Parametrised burst reader for the block ROMs holding HMM-Viterbi model tables, e.g. emission and transition log-probabilities. It takes a base address and length, issues sequential reads to a synchronous-read ROM with configurable latency, and presents the words on a valid/ready stream to the Viterbi datapath. It handles back-pressure without losing in-flight ROM data and supports a circular mode for repeated per-frame table sweeps.

## Interface
Parameters:
- ADDR_W, 13: ROM address width.
- DATA_W, 14: ROM word width.
- ROM_LAT, 1: ROM read latency in cycles (legal 1..3), measured from the edge sampling rom_en to the edge where rom_data is valid.

Ports:
- clk  in  1  single clock; all logic is rising-edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  launches a burst; sampled only in IDLE.
- base_addr  in  ADDR_W  first address; captured on start.
- length  in  ADDR_W  number of words per pass; captured on start. 0 means empty burst.
- circ  in  1  circular mode; captured on start.
- stop  in  1  ends a burst early (abort, or end of a circular run).
- busy  out  1  high from the start edge until done.
- done  out  1  one-cycle pulse at the end of a burst.
- rom_en  out  1  ROM read enable.
- rom_addr  out  ADDR_W  ROM address.
- rom_data  in  DATA_W  ROM read data.
- m_valid  out  1  stream valid.
- m_ready  in  1  stream ready.
- m_data  out  DATA_W  stream word.
- m_index  out  ADDR_W  offset of the word within the pass (0..length-1).
- m_last  out  1  marks the final word of each pass.

## Operation
State machine:
- IDLE
  - start with length≠0: go to ISSUE.
  - start with length=0: done pulses next cycle and the block stays in IDLE.
  - start is ignored in every other state.
- ISSUE
  - Issue one read per cycle while credit allows.
  - rom_addr = (base_addr + offset) mod 2^ADDR_W; the address wraps naturally at the top of the ROM.
  - After offset length-1 has been issued:
    - circ=0: go to DRAIN.
    - circ=1: offset returns to 0 and issuing continues.
- DRAIN: wait until every in-flight read has arrived and the output FIFO is empty, then pulse done and go to IDLE.

Buffering:
- Output FIFO depth is ROM_LAT+2.
- Credit rule: issue a read only when fifo_count + inflight < ROM_LAT+2. Data is never dropped or overwritten.
- Each FIFO entry carries {data, index, last}.

Stop:
- stop in ISSUE: no further reads are issued from the next edge. Go to DRAIN. Words already issued are still delivered.
- stop in IDLE or DRAIN: no effect.
- stop and the final issue of a non-circular pass in the same cycle: that final issue still happens.

Reset:
- Reset mid-burst discards in-flight reads and FIFO contents. The state returns to IDLE.
- Reset values: busy=0, done=0, rom_en=0, rom_addr=0, m_valid=0, m_data=0, m_index=0, m_last=0.

## Timing
- rom_en and rom_addr are registered outputs.
- Start is sampled at edge E0:
  - rom_en goes high after E0, with rom_addr=base_addr.
  - The ROM captures the read at E1.
  - rom_data is captured into the FIFO at E(1+ROM_LAT).
  - m_valid rises after that same edge: start-to-first-valid latency is ROM_LAT+1 cycles.
- Throughput: one word per cycle while m_ready stays high.
- When m_ready drops, issuing stops within one cycle, once credit runs out.
- Handshake:
  - A transfer occurs when m_valid && m_ready.
  - m_data, m_index and m_last hold stable while m_valid && !m_ready.
  - m_valid does not depend combinationally on m_ready.
- done is registered and pulses on the cycle after the last transfer, or after the drain completes.
- busy falls in the same cycle done is high.

## Structure
- Shared package brom_pkg:
  - state enum {IDLE, ISSUE, DRAIN};
  - ROM_LAT_MAX = 3;
  - function fifo_depth(lat) = lat+2.
- Sub-module brom_burst_fifo: synchronous FIFO parametrised by width and depth, with count output and registered head.
- The top level holds the FSM, offset counter, in-flight shift register of length ROM_LAT (tagging index/last) and credit logic.

## Test plan
All scenarios use a bench ROM model with data = {1'b0, addr}, ADDR_W=13, DATA_W=14.

- ROM_LAT=1, base=0x010, length=4, m_ready=1:
  - m_data = 0x010..0x013 on consecutive cycles, first valid 2 cycles after start;
  - m_last on the 4th word;
  - done is a one-cycle pulse.
- Top-of-ROM wrap, base=0x1FFE, length=4:
  - rom_addr sequence 0x1FFE, 0x1FFF, 0x0000, 0x0001;
  - m_index 0..3.
- ROM_LAT=3, length=16, m_ready toggled pseudo-randomly:
  - all 16 words delivered in order, no loss or duplication;
  - inflight+count never exceeds 5.
- circ=1, length=3, stop asserted after 7 transfers:
  - m_index sequence 0,1,2,0,1,2,0,...;
  - m_last on each index 2;
  - done after in-flight words drain;
  - no read issued after the stop edge.
- Edge inputs:
  - length=0 gives done one cycle after start, with no rom_en;
  - start while busy is ignored.
- rst_n pulsed low mid-burst, with 2 words in the FIFO:
  - all outputs take their reset values immediately;
  - the next start behaves as in the first scenario.
